// File: rtl/u_hat_packer_if.sv
// Decision-pair input and result-memory write bus for u_hat_packer.
// master = decoder/testbench side, slave = packer side.
interface u_hat_packer_if #(
    parameter int unsigned KMAX = 140,
    parameter int unsigned AW   = 11
);
    logic            pkt_start;
    logic [7:0]      K;
    logic            pair_valid;
    logic            u_hat_1;
    logic            u_hat_2;
    logic            info_1;
    logic            info_2;
    logic            pair_last;
    logic            busy;
    logic            wen;
    logic [AW-1:0]   waddr;
    logic [KMAX-1:0] wdata;
    logic            err;

    modport master (
        output pkt_start, K, pair_valid, u_hat_1, u_hat_2, info_1, info_2, pair_last,
        input  busy, wen, waddr, wdata, err
    );

    modport slave (
        input  pkt_start, K, pair_valid, u_hat_1, u_hat_2, info_1, info_2, pair_last,
        output busy, wen, waddr, wdata, err
    );
endinterface

// File: rtl/u_hat_packer.sv
// Packs info-bit decisions LSB-first into a KMAX-bit word and writes one word per codeword
// to the result memory at an auto-incrementing address.
module u_hat_packer #(
    parameter int unsigned KMAX = 140,
    parameter int unsigned AW   = 11
) (
    input logic           clk,
    input logic           rst_n,
    u_hat_packer_if.slave bus
);
    localparam logic [7:0] KMaxC = 8'(KMAX);

    typedef enum logic [1:0] {StIdle, StCollect, StWrite} state_e;

    state_e          state_q, state_d;
    logic [7:0]      k_q, k_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [KMAX-1:0] buf_q, buf_d;
    logic [KMAX-1:0] wdata_q, wdata_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic            err_q, err_d;
    logic            wen_q, wen_d;
    logic            busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        err_d   = err_q;
        wen_d   = 1'b0;

        unique case (state_q)
            StIdle, StCollect: begin
                if (bus.pkt_start) begin
                    // Oversized K is clamped and flagged; abort in COLLECT discards the word.
                    k_d     = (bus.K > KMaxC) ? KMaxC : bus.K;
                    err_d   = (bus.K > KMaxC);
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = StCollect;
                end else if (state_q == StCollect && bus.pair_valid) begin
                    if (bus.info_1) begin
                        if (cnt_d < k_q) begin
                            buf_d[cnt_d] = bus.u_hat_1;
                            cnt_d        = cnt_d + 8'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (bus.info_2) begin
                        if (cnt_d < k_q) begin
                            buf_d[cnt_d] = bus.u_hat_2;
                            cnt_d        = cnt_d + 8'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (bus.pair_last) begin
                        if (cnt_d != k_q) begin
                            err_d = 1'b1;
                        end
                        // Final pair lands in wdata on the same edge that raises wen.
                        wdata_d = buf_d;
                        wen_d   = 1'b1;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                waddr_d = waddr_q + AW'(1);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.wen   = wen_q;
    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_u_hat_packer.sv
// Scoreboard bench for u_hat_packer: stimulus pushes expected writes, a negedge monitor
// pops and compares whenever wen is seen.
module tb_u_hat_packer;
    logic clk;
    logic rst_n;

    u_hat_packer_if #(.KMAX(140), .AW(11)) bus ();

    u_hat_packer #(.KMAX(140), .AW(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [10:0]  addr;
        logic [139:0] data;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [139:0] act, input logic [139:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [10:0] a, input logic [139:0] d, input logic e);
        exp_t x;
        x.addr = a;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] k);
        bus.pkt_start = 1'b1;
        bus.K         = k;
        tick();
        bus.pkt_start = 1'b0;
    endtask

    task automatic pair(input logic i1, input logic u1, input logic i2, input logic u2,
                        input logic last);
        bus.pair_valid = 1'b1;
        bus.info_1     = i1;
        bus.u_hat_1    = u1;
        bus.info_2     = i2;
        bus.u_hat_2    = u2;
        bus.pair_last  = last;
        tick();
        bus.pair_valid = 1'b0;
        bus.pair_last  = 1'b0;
        bus.info_1     = 1'b0;
        bus.info_2     = 1'b0;
    endtask

    // Monitor: every wen cycle must match the oldest expected write.
    always @(negedge clk) begin
        exp_t e;
        if (bus.wen === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wen: got write at waddr %0d, required no write",
                         bus.waddr);
            end else begin
                e = sb.pop_front();
                chk("waddr", 140'(bus.waddr), 140'(e.addr));
                chk("wdata", bus.wdata, e.data);
                chk("err", 140'(bus.err), 140'(e.err));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [139:0] big;
        logic [139:0] d;
        logic [10:0]  a;

        rst_n          = 1'b0;
        bus.pkt_start  = 1'b0;
        bus.K          = '0;
        bus.pair_valid = 1'b0;
        bus.u_hat_1    = 1'b0;
        bus.u_hat_2    = 1'b0;
        bus.info_1     = 1'b0;
        bus.info_2     = 1'b0;
        bus.pair_last  = 1'b0;
        tick();
        tick();
        chk("rst_busy", 140'(bus.busy), 140'(0));
        chk("rst_wen", 140'(bus.wen), 140'(0));
        chk("rst_waddr", 140'(bus.waddr), 140'(0));
        chk("rst_wdata", bus.wdata, 140'(0));
        chk("rst_err", 140'(bus.err), 140'(0));
        rst_n = 1'b1;
        tick();

        // K=4: info bits 1,0,1,1 -> 0b1101
        push(11'd0, 140'hD, 1'b0);
        start(8'd4);
        chk("busy_after_start", 140'(bus.busy), 140'(1));
        pair(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pair(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        pair(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        pair(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("busy_in_write", 140'(bus.busy), 140'(1));
        // pkt_start and pair_valid during WRITE are ignored
        bus.pkt_start  = 1'b1;
        bus.K          = 8'd5;
        bus.pair_valid = 1'b1;
        bus.info_1     = 1'b1;
        tick();
        bus.pkt_start  = 1'b0;
        bus.pair_valid = 1'b0;
        bus.info_1     = 1'b0;
        chk("busy_after_write", 140'(bus.busy), 140'(0));
        chk("waddr_after_write", 140'(bus.waddr), 140'(1));

        // Back-to-back codewords, pkt_start the cycle after wen
        push(11'd1, 140'h1, 1'b0);
        start(8'd2);
        pair(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("busy_gap", 140'(bus.busy), 140'(0));
        push(11'd2, 140'h6, 1'b0);
        start(8'd3);
        chk("busy_second", 140'(bus.busy), 140'(1));
        pair(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        pair(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();

        // Overflow: K=2, three info bits of 1
        push(11'd3, 140'h3, 1'b1);
        start(8'd2);
        pair(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        pair(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("err_held", 140'(bus.err), 140'(1));
        push(11'd4, 140'h1, 1'b0);
        start(8'd1);
        chk("err_cleared", 140'(bus.err), 140'(0));
        pair(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();

        // Underflow: K=3, two info bits; lone pair_last ignored
        push(11'd5, 140'h3, 1'b1);
        start(8'd3);
        bus.pair_last = 1'b1;
        tick();
        bus.pair_last = 1'b0;
        chk("busy_lone_last", 140'(bus.busy), 140'(1));
        pair(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();

        // Abort after 5 pairs, restart with K=200 clamped to 140
        start(8'd10);
        for (int j = 0; j < 5; j++) pair(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        start(8'd200);
        chk("err_clamp", 140'(bus.err), 140'(1));
        chk("busy_restart", 140'(bus.busy), 140'(1));
        chk("waddr_abort", 140'(bus.waddr), 140'(6));
        big = '0;
        for (int j = 0; j < 70; j++) begin
            big[2*j]   = j[0];
            big[2*j+1] = j[1];
        end
        push(11'd6, big, 1'b1);
        for (int j = 0; j < 70; j++) pair(1'b1, j[0], 1'b1, j[1], (j == 69));
        tick();
        chk("waddr_after_full", 140'(bus.waddr), 140'(7));

        // Asynchronous reset mid-COLLECT
        start(8'd4);
        pair(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midrst_busy", 140'(bus.busy), 140'(0));
        chk("midrst_wen", 140'(bus.wen), 140'(0));
        chk("midrst_waddr", 140'(bus.waddr), 140'(0));
        chk("midrst_wdata", bus.wdata, 140'(0));
        chk("midrst_err", 140'(bus.err), 140'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 2049 codewords: address wraps 2047 -> 0
        for (int i = 0; i < 2049; i++) begin
            d    = '0;
            d[0] = i[0];
            d[1] = i[1];
            a    = i[10:0];
            push(a, d, 1'b0);
            start(8'd2);
            pair(1'b1, i[0], 1'b1, i[1], 1'b1);
            tick();
        end
        chk("waddr_wrapped", 140'(bus.waddr), 140'(1));

        tick();
        tick();
        chk("sb_empty", 140'(sb.size()), 140'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
